// File: rtl/ocp_master_fsm_pkg.sv
// ocp_master_fsm_pkg: OCP encodings, FSM state codes and width defaults
// shared by the OCP master request engine and its bench.
package ocp_master_fsm_pkg;

  localparam int DEF_MDATA_WIDTH = 8;
  localparam int DEF_SDATA_WIDTH = 8;
  localparam int DEF_MADDR_WIDTH = 64;
  localparam int BLEN_WIDTH      = 10;

  typedef logic [2:0] mcmd_t;
  localparam mcmd_t MCMD_IDLE = 3'b000;
  localparam mcmd_t MCMD_WR   = 3'b001;
  localparam mcmd_t MCMD_RD   = 3'b010;
  localparam mcmd_t MCMD_RDEX = 3'b011;
  localparam mcmd_t MCMD_RDL  = 3'b100;
  localparam mcmd_t MCMD_WRNP = 3'b101;
  localparam mcmd_t MCMD_WRC  = 3'b110;
  localparam mcmd_t MCMD_BCST = 3'b111;

  typedef logic [1:0] sresp_t;
  localparam sresp_t SRESP_NULL = 2'b00;
  localparam sresp_t SRESP_DVA  = 2'b01;
  localparam sresp_t SRESP_FAIL = 2'b10;
  localparam sresp_t SRESP_ERR  = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_WRITE     = 2'd1;
  localparam state_t ST_READ      = 2'd2;
  localparam state_t ST_WAIT_RESP = 2'd3;

  typedef logic [BLEN_WIDTH-1:0] blen_t;

  // A zero-length request still moves one beat.
  function automatic blen_t norm_blen(input blen_t len);
    return (len == '0) ? blen_t'(1) : len;
  endfunction

endpackage

// File: rtl/ocp_master_fsm.sv
// ocp_master_fsm: bridge read/write -> OCP request phases (bursted writes,
// single reads w/ SResp), gated Clk out; registered MCmd/MAddr/MData/etc.
module ocp_master_fsm
  import ocp_master_fsm_pkg::*;
#(
  parameter int MDATA_WIDTH = DEF_MDATA_WIDTH,
  parameter int SDATA_WIDTH = DEF_SDATA_WIDTH,
  parameter int MADDR_WIDTH = DEF_MADDR_WIDTH
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic [MADDR_WIDTH-1:0] address,
  input  logic [9:0]             burst_length,
  input  logic                   read_request,
  input  logic                   write_request,
  input  logic [MDATA_WIDTH-1:0] write_data,
  output logic [MDATA_WIDTH-1:0] read_data,
  input  logic                   EnableClk,
  output logic                   Clk,
  input  logic                   SCmdAccept,
  input  logic [SDATA_WIDTH-1:0] SData,
  input  logic [1:0]             SResp,
  output logic [MADDR_WIDTH-1:0] MAddr,
  output logic [2:0]             MCmd,
  output logic [MDATA_WIDTH-1:0] MData,
  output logic [9:0]             MBurstLength,
  output logic                   MReqLast
);

  state_t      state;
  logic [9:0]  beat;
  logic        last_beat;
  logic [9:0]  beat_nxt;
  logic [9:0]  blen_in;

  assign Clk       = sys_clk & EnableClk;
  assign last_beat = (beat == MBurstLength);
  assign beat_nxt  = beat + 10'd1;
  assign blen_in   = norm_blen(burst_length);

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      MCmd         <= MCMD_IDLE;
      MAddr        <= '0;
      MData        <= '0;
      MBurstLength <= 10'd1;
      MReqLast     <= 1'b0;
      read_data    <= '0;
      beat         <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (write_request) begin
            MAddr        <= address;
            MData        <= write_data;
            MBurstLength <= blen_in;
            beat         <= 10'd1;
            MReqLast     <= (blen_in == 10'd1);
            MCmd         <= MCMD_WR;
            state        <= ST_WRITE;
          end else if (read_request) begin
            MAddr        <= address;
            MBurstLength <= 10'd1;
            MReqLast     <= 1'b1;
            MCmd         <= MCMD_RD;
            state        <= ST_READ;
          end
        end
        ST_WRITE: begin
          if (SCmdAccept) begin
            if (last_beat) begin
              MCmd     <= MCMD_IDLE;
              MReqLast <= 1'b0;
              beat     <= '0;
              state    <= ST_IDLE;
            end else begin
              // bridge already shows the next beat at this edge
              beat     <= beat_nxt;
              MAddr    <= address;
              MData    <= write_data;
              MReqLast <= (beat_nxt == MBurstLength);
            end
          end
        end
        ST_READ: begin
          if (SCmdAccept) begin
            MCmd     <= MCMD_IDLE;
            MReqLast <= 1'b0;
            state    <= ST_WAIT_RESP;
          end
        end
        ST_WAIT_RESP: begin
          unique case (SResp)
            SRESP_DVA: begin
              read_data <= MDATA_WIDTH'(SData);
              state     <= ST_IDLE;
            end
            SRESP_FAIL, SRESP_ERR: begin
              read_data <= '0;
              state     <= ST_IDLE;
            end
            default: ;
          endcase
        end
        default: begin
          MCmd  <= MCMD_IDLE;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ocp_master_fsm.sv
// tb_ocp_master_fsm: directed scoreboard bench for ocp_master_fsm
// (reset, write/read, burst, backpressure, error, async reset, Clk gate).
module tb_ocp_master_fsm;
  import ocp_master_fsm_pkg::*;

  localparam int MDW = 8;
  localparam int SDW = 8;
  localparam int MAW = 64;

  logic           sys_clk = 1'b0;
  logic           reset;
  logic [MAW-1:0] address;
  logic [9:0]     burst_length;
  logic           read_request;
  logic           write_request;
  logic [MDW-1:0] write_data;
  logic [MDW-1:0] read_data;
  logic           EnableClk;
  logic           Clk;
  logic           SCmdAccept;
  logic [SDW-1:0] SData;
  logic [1:0]     SResp;
  logic [MAW-1:0] MAddr;
  logic [2:0]     MCmd;
  logic [MDW-1:0] MData;
  logic [9:0]     MBurstLength;
  logic           MReqLast;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [MAW-1:0] addr;
    logic [MDW-1:0] data;
    logic [9:0]     blen;
    logic           last;
  } beat_t;

  beat_t          wq[$];
  logic [MDW-1:0] rq[$];

  ocp_master_fsm #(
    .MDATA_WIDTH(MDW),
    .SDATA_WIDTH(SDW),
    .MADDR_WIDTH(MAW)
  ) dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .address      (address),
    .burst_length (burst_length),
    .read_request (read_request),
    .write_request(write_request),
    .write_data   (write_data),
    .read_data    (read_data),
    .EnableClk    (EnableClk),
    .Clk          (Clk),
    .SCmdAccept   (SCmdAccept),
    .SData        (SData),
    .SResp        (SResp),
    .MAddr        (MAddr),
    .MCmd         (MCmd),
    .MData        (MData),
    .MBurstLength (MBurstLength),
    .MReqLast     (MReqLast)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic push_wr(input logic [MAW-1:0] a, input logic [MDW-1:0] d,
                         input logic [9:0] bl, input logic l);
    beat_t b;
    b.addr = a;
    b.data = d;
    b.blen = bl;
    b.last = l;
    wq.push_back(b);
  endtask

  // peek=1 compares without consuming (beat held under backpressure)
  task automatic chk_beat(input string tag, input bit peek);
    beat_t b;
    if (wq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed empty_queue expected beat", tag);
    end else begin
      b = wq[0];
      if (!peek) void'(wq.pop_front());
      chk({tag, "_cmd"}, 64'(MCmd), 64'(MCMD_WR));
      chk({tag, "_addr"}, 64'(MAddr), 64'(b.addr));
      chk({tag, "_data"}, 64'(MData), 64'(b.data));
      chk({tag, "_blen"}, 64'(MBurstLength), 64'(b.blen));
      chk({tag, "_last"}, 64'(MReqLast), 64'(b.last));
    end
  endtask

  task automatic chk_rd(input string tag);
    logic [MDW-1:0] e;
    if (rq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed empty_queue expected data", tag);
    end else begin
      e = rq.pop_front();
      chk(tag, 64'(read_data), 64'(e));
    end
  endtask

  initial begin
    reset         = 1'b0;
    EnableClk     = 1'b1;
    address       = {$urandom, $urandom};
    burst_length  = 10'($urandom);
    read_request  = 1'($urandom);
    write_request = 1'($urandom);
    write_data    = 8'($urandom);
    SCmdAccept    = 1'($urandom);
    SData         = 8'($urandom);
    SResp         = 2'($urandom);

    // reset held with random inputs
    step();
    step();
    chk("rst_mcmd", 64'(MCmd), 64'(MCMD_IDLE));
    chk("rst_maddr", 64'(MAddr), 64'd0);
    chk("rst_mdata", 64'(MData), 64'd0);
    chk("rst_blen", 64'(MBurstLength), 64'd1);
    chk("rst_last", 64'(MReqLast), 64'd0);
    chk("rst_rdata", 64'(read_data), 64'd0);

    read_request  = 1'b0;
    write_request = 1'b0;
    SCmdAccept    = 1'b0;
    SResp         = SRESP_NULL;
    reset         = 1'b1;
    step();
    step();
    chk("idle_mcmd", 64'(MCmd), 64'(MCMD_IDLE));
    chk("idle_last", 64'(MReqLast), 64'd0);

    // single write, accept after 2 cycles
    address       = '1;
    write_data    = 8'hFF;
    burst_length  = 10'd1;
    write_request = 1'b1;
    push_wr('1, 8'hFF, 10'd1, 1'b1);
    step();
    write_request = 1'b0;
    address       = 64'h1234;
    write_data    = 8'h00;
    chk_beat("sw_b0", 1'b1);
    step();
    chk_beat("sw_b0_hold", 1'b0);
    SCmdAccept = 1'b1;
    step();
    SCmdAccept = 1'b0;
    chk("sw_done", 64'(MCmd), 64'(MCMD_IDLE));

    // single read, DVA
    address      = '1;
    read_request = 1'b1;
    rq.push_back(8'hFF);
    step();
    read_request = 1'b0;
    chk("sr_cmd", 64'(MCmd), 64'(MCMD_RD));
    chk("sr_addr", 64'(MAddr), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sr_last", 64'(MReqLast), 64'd1);
    chk("sr_blen", 64'(MBurstLength), 64'd1);
    step();
    chk("sr_cmd_hold", 64'(MCmd), 64'(MCMD_RD));
    SCmdAccept = 1'b1;
    step();
    SCmdAccept = 1'b0;
    chk("sr_wait_cmd", 64'(MCmd), 64'(MCMD_IDLE));
    SData = 8'h5A;
    step();
    step();
    chk("sr_null_keep", 64'(read_data), 64'd0);
    SResp = SRESP_DVA;
    SData = 8'hFF;
    step();
    SResp = SRESP_NULL;
    SData = 8'h00;
    chk_rd("sr_dva");
    chk("sr_idle", 64'(MCmd), 64'(MCMD_IDLE));

    // 4-beat burst, continuous accept; burst_length changes mid-burst
    burst_length  = 10'd4;
    address       = 64'h0;
    write_data    = 8'h0;
    write_request = 1'b1;
    SCmdAccept    = 1'b1;
    for (int i = 0; i < 4; i++)
      push_wr(64'(4 * i), 8'(i), 10'd4, (i == 3));
    step();
    write_request = 1'b0;
    burst_length  = 10'd7;
    for (int i = 0; i < 4; i++) begin
      chk_beat($sformatf("bu_b%0d", i), 1'b0);
      address    = 64'(4 * (i + 1));
      write_data = 8'(i + 1);
      step();
    end
    SCmdAccept = 1'b0;
    chk("bu_done", 64'(MCmd), 64'(MCMD_IDLE));
    chk("bu_q_empty", 64'(wq.size()), 64'd0);

    // priority + backpressure, burst_length 0 -> 1
    address       = 64'hDEAD_BEEF_0000_0010;
    write_data    = 8'hA5;
    burst_length  = 10'd0;
    write_request = 1'b1;
    read_request  = 1'b1;
    push_wr(64'hDEAD_BEEF_0000_0010, 8'hA5, 10'd1, 1'b1);
    step();
    write_request = 1'b0;
    read_request  = 1'b0;
    address       = 64'h0;
    write_data    = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      chk_beat($sformatf("bp_c%0d", i), (i < 2));
      if (i < 2) step();
    end
    SCmdAccept = 1'b1;
    step();
    SCmdAccept = 1'b0;
    chk("bp_done", 64'(MCmd), 64'(MCMD_IDLE));

    // read error path
    address      = 64'h40;
    read_request = 1'b1;
    rq.push_back(8'h00);
    step();
    read_request = 1'b0;
    SCmdAccept   = 1'b1;
    chk("re_cmd", 64'(MCmd), 64'(MCMD_RD));
    step();
    SCmdAccept = 1'b0;
    chk("re_wait", 64'(MCmd), 64'(MCMD_IDLE));
    SResp = SRESP_ERR;
    SData = 8'hAA;
    step();
    SResp = SRESP_NULL;
    chk_rd("re_err");
    chk("re_idle", 64'(MCmd), 64'(MCMD_IDLE));

    // async reset during beat 2
    burst_length  = 10'd4;
    address       = 64'h100;
    write_data    = 8'h10;
    write_request = 1'b1;
    SCmdAccept    = 1'b1;
    push_wr(64'h100, 8'h10, 10'd4, 1'b0);
    push_wr(64'h104, 8'h11, 10'd4, 1'b0);
    step();
    write_request = 1'b0;
    chk_beat("mr_b0", 1'b0);
    address    = 64'h104;
    write_data = 8'h11;
    step();
    chk_beat("mr_b1", 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_mcmd", 64'(MCmd), 64'(MCMD_IDLE));
    chk("mr_maddr", 64'(MAddr), 64'd0);
    chk("mr_mdata", 64'(MData), 64'd0);
    chk("mr_blen", 64'(MBurstLength), 64'd1);
    chk("mr_last", 64'(MReqLast), 64'd0);
    SCmdAccept = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("mr_idle", 64'(MCmd), 64'(MCMD_IDLE));

    // Clk gating
    EnableClk = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("clk_en_hi", 64'(Clk), 64'd1);
    @(negedge sys_clk);
    #1;
    chk("clk_en_lo", 64'(Clk), 64'd0);
    EnableClk = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("clk_dis_hi", 64'(Clk), 64'd0);
    EnableClk = 1'b1;
    #1;
    chk("clk_reen_hi", 64'(Clk), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ocp_master_fsm.md
Name: ocp_master_fsm

Overview:
OCP 3.0 master-side request engine between the PCIe bridge and the OCP bus. Converts bridge read/write requests into OCP request phases (MCmd/MAddr/MData/MBurstLength/MReqLast) with SCmdAccept handshaking. Writes may be precise bursts; reads are single-beat with SResp capture. Also forwards a gated OCP clock.

Parameters:
MDATA_WIDTH, 8, master write data width (MData, write_data, read_data)
SDATA_WIDTH, 8, slave read data width (SData); must be <= MDATA_WIDTH
MADDR_WIDTH, 64, address width (address, MAddr)

Ports:
sys_clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
address  in  MADDR_WIDTH  bridge address for the current beat
burst_length  in  10  write burst beat count, sampled at request start; 0 treated as 1
read_request  in  1  bridge read request level
write_request  in  1  bridge write request level
write_data  in  MDATA_WIDTH  bridge write data for the current beat
read_data  out  MDATA_WIDTH  last read response data
EnableClk  in  1  OCP clock enable
Clk  out  1  OCP clock = sys_clk AND EnableClk
SCmdAccept  in  1  slave accepts current request beat
SData  in  SDATA_WIDTH  slave response data
SResp  in  2  NULL=00, DVA=01, FAIL=10, ERR=11
MAddr  out  MADDR_WIDTH  request address
MCmd  out  3  IDLE=000, WR=001, RD=010 (others never driven)
MData  out  MDATA_WIDTH  write data
MBurstLength  out  10  burst length of current request
MReqLast  out  1  high on final request beat

Behaviour:
- Reset (reset=0, async): state IDLE; MCmd=IDLE, MAddr=0, MData=0, MBurstLength=1, MReqLast=0, read_data=0, beat counter=0. Reset mid-burst abandons the transaction immediately.
- All outputs except Clk are registered. Clk is combinational.
- States: IDLE, WRITE, READ, WAIT_RESP.
- IDLE: MCmd=IDLE, MReqLast=0. write_request=1 has priority over read_request. On write_request: MAddr<=address, MData<=write_data, MBurstLength<=max(burst_length,1), beat<=1, MReqLast<=(length==1), go WRITE. On read_request (no write_request): MAddr<=address, MBurstLength<=1, MReqLast<=1, go READ. MCmd is valid one cycle after the request is sampled.
- WRITE: MCmd=WR. Request fields are held stable while SCmdAccept=0. On a rising edge with SCmdAccept=1:
  - last beat (beat==MBurstLength): go IDLE, MCmd<=IDLE.
  - otherwise: beat++, MAddr<=address, MData<=write_data (the bridge presents the next beat at the accept edge), MReqLast<=(beat+1==MBurstLength), stay WRITE.
  - MBurstLength is constant for the whole burst.
  - Writes expect no response; SResp is ignored in WRITE.
- READ: MCmd=RD, held until SCmdAccept=1, then MCmd<=IDLE and go WAIT_RESP.
- WAIT_RESP: MCmd=IDLE.
  - SResp=DVA: read_data<=SData (zero-extended), go IDLE.
  - SResp=FAIL or ERR: read_data<=0, go IDLE.
  - SResp=NULL: wait indefinitely (no timeout).
- Request inputs are ignored outside IDLE. A level still high on return to IDLE starts a new transaction, so the bridge must drop the request within one cycle of the final accept.
- SCmdAccept in IDLE or WAIT_RESP is ignored.
- EnableClk affects only Clk; the FSM runs on sys_clk.

Decomposition:
- Shared package: MCmd encodings (IDLE, WR, RD, RDEX, RDL, WRNP, WRC, BCST), SResp encodings (NULL, DVA, FAIL, ERR), FSM state enum, width defaults.
- Single module; no sub-module needed.

Test Plan:
- Reset: hold reset=0 with random inputs -> MCmd=000, MAddr=0, MReqLast=0, read_data=0; release -> IDLE persists with no requests.
- Single write: address=FFFF_FFFF_FFFF_FFFF, write_data=FF, write_request=1, burst_length=1, SCmdAccept after 2 cycles -> MCmd=WR, MAddr/MData held, MReqLast=1, MBurstLength=1 until the accept edge; MCmd=IDLE the next cycle.
- Single read: read_request=1, address=all-ones, accept after 1 cycle, then SResp=DVA with SData=FF -> MCmd=RD then IDLE; read_data=FF after the DVA edge; SResp=NULL cycles leave read_data unchanged.
- 4-beat write burst: burst_length=4, beats addr 0/4/8/C with data 0/1/2/3, SCmdAccept=1 continuously -> four WR beats with matching MAddr/MData, MBurstLength=4 throughout, MReqLast only on beat 4, then IDLE.
- Backpressure and priority: write_request and read_request both 1, SCmdAccept low 3 cycles -> WR issued with outputs stable for 3 cycles; read error path: SResp=ERR -> read_data=0, IDLE.
- Reset mid-burst: assert reset=0 during beat 2 of a 4-beat burst -> outputs reset immediately (async); Clk equals sys_clk only while EnableClk=1.
